// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES job scheduler.
//   - state_t / ST_* : job FSM encodings (plain logic constants)
//   - CH_W           : width of a channel index
//   - WCNT_W         : width of the per-job word counters
//   - WORDS_PER_BLOCK: 32-bit words per 128-bit AES block
//   - total_words()  : block count -> word count
package aes_sched_pkg;

    localparam int CH_W            = 1;
    localparam int WCNT_W          = 10;
    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FLUSH = 3'd1;
    localparam state_t ST_CFG   = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // 255 blocks * 4 = 1020 words, which still fits the 10-bit counters.
    function automatic logic [WCNT_W-1:0] total_words(input logic [WCNT_W-3:0] len);
        return WCNT_W'(len) * WCNT_W'(WORDS_PER_BLOCK);
    endfunction

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Bundle of all requester-side and datapath-side signals of the job arbiter.
//   slave  : the arbiter itself (consumes i_*, drives o_*)
//   master : the environment (requesters, AES datapath / FIFOs)
// Per-channel fields are packed with channel c in slice c.
interface aes_job_arbiter_if #(
    parameter int N_CH  = 2,
    parameter int LEN_W = 8
);
    logic [N_CH-1:0]       i_req;
    logic [N_CH-1:0]       i_endec;
    logic [128*N_CH-1:0]   i_key;
    logic [LEN_W*N_CH-1:0] i_len;
    logic [N_CH-1:0]       i_in_valid;
    logic [32*N_CH-1:0]    i_in_data;
    logic [N_CH-1:0]       o_in_ready;
    logic [N_CH-1:0]       o_out_valid;
    logic [31:0]           o_out_data;
    logic [N_CH-1:0]       i_out_ready;
    logic [N_CH-1:0]       o_grant;
    logic [N_CH-1:0]       o_done;
    logic                  o_rst_control;
    logic                  o_param_load;
    logic                  o_endec;
    logic                  o_key_load;
    logic [31:0]           o_key_data_1;
    logic [31:0]           o_key_data_2;
    logic [31:0]           o_key_data_3;
    logic [31:0]           o_key_data_4;
    logic                  o_write_fifoIn;
    logic [31:0]           o_data_fifoIn;
    logic                  i_full_fifoIn;
    logic                  o_read_fifoOut;
    logic                  i_empty_fifoOut;
    logic [31:0]           i_q_fifoOut;

    modport slave (
        input  i_req, i_endec, i_key, i_len, i_in_valid, i_in_data, i_out_ready,
               i_full_fifoIn, i_empty_fifoOut, i_q_fifoOut,
        output o_in_ready, o_out_valid, o_out_data, o_grant, o_done,
               o_rst_control, o_param_load, o_endec, o_key_load,
               o_key_data_1, o_key_data_2, o_key_data_3, o_key_data_4,
               o_write_fifoIn, o_data_fifoIn, o_read_fifoOut
    );

    modport master (
        output i_req, i_endec, i_key, i_len, i_in_valid, i_in_data, i_out_ready,
               i_full_fifoIn, i_empty_fifoOut, i_q_fifoOut,
        input  o_in_ready, o_out_valid, o_out_data, o_grant, o_done,
               o_rst_control, o_param_load, o_endec, o_key_load,
               o_key_data_1, o_key_data_2, o_key_data_3, o_key_data_4,
               o_write_fifoIn, o_data_fifoIn, o_read_fifoOut
    );

endinterface

// File: rtl/aes_skid2.sv
// Two-entry result buffer between the output FIFO and the owning channel.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_rd_allow    : caller permits a FIFO read this cycle (FIFO non-empty,
//                   job still has words to fetch)
//   o_rd          : FIFO read strobe actually issued
//   i_q           : FIFO data, valid the cycle after o_rd
//   i_pop         : consumer takes the head word (only when o_valid)
//   o_valid/o_data: head word presented to the consumer
// A read is only issued while buffered + in-flight words < 2, so every
// requested word always has a slot when it arrives.
module aes_skid2 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd_allow,
    output logic        o_rd,
    input  logic [31:0] i_q,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [31:0] o_data
);

    logic [1:0]  cnt_q, cnt_d;
    logic        infl_q, infl_d;
    logic [31:0] buf0_q, buf0_d;
    logic [31:0] buf1_q, buf1_d;
    logic        push;

    always_comb begin
        push    = infl_q;
        // Bypass the arriving word when the buffer is empty, giving
        // read-to-output latency of one cycle and 1 word/cycle streaming.
        o_valid = (cnt_q != 2'd0) | infl_q;
        o_data  = (cnt_q != 2'd0) ? buf0_q : (infl_q ? i_q : 32'd0);
        o_rd    = i_rd_allow & (({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2);
        infl_d  = o_rd;

        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (push && !i_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (i_pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end

        if (i_pop && cnt_q != 2'd0) begin
            buf0_d = buf1_q;
        end
        // With a word in flight the buffer holds at most one entry.
        if (push) begin
            if (cnt_q == 2'd0) begin
                if (!i_pop) begin
                    buf0_d = i_q;
                end
            end else if (i_pop) begin
                buf0_d = i_q;
            end else begin
                buf1_d = i_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    always_ff @(posedge i_clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin scheduler granting the single AES engine to one of two
// channels. Per job: flush the datapath, load key/direction, stream 4*len
// words into the input FIFO and return 4*len result words to the owner.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : requests, per-channel key/len/endec, input and result
//                  handshakes, grant/done, datapath controls and FIFO strobes
module aes_job_arbiter #(
    parameter int N_CH  = 2,
    parameter int LEN_W = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    aes_job_arbiter_if.slave bus
);
    import aes_sched_pkg::*;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [N_CH-1:0]     grant_q, grant_d;
    logic [WCNT_W-1:0]   total_q, total_d;
    logic [WCNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [WCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic                endec_q, endec_d;
    logic [127:0]        key_q, key_d;

    logic [CH_W-1:0]     sel;
    logic [127:0]        key_sel;
    logic [LEN_W-1:0]    len_sel;
    logic                run, busy, in_room, wr, rd_allow, pop;
    logic [31:0]         in_data_g;
    logic                sk_rd, sk_valid;
    logic [31:0]         sk_data;

    // Round-robin pick: the pointer channel wins if requesting, else the other.
    always_comb begin
        sel = rr_q;
        if (!bus.i_req[rr_q]) begin
            sel = ~rr_q;
        end
        key_sel = sel[0] ? bus.i_key[255:128] : bus.i_key[127:0];
        len_sel = sel[0] ? bus.i_len[2*LEN_W-1:LEN_W] : bus.i_len[LEN_W-1:0];
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        busy      = (state_q != ST_IDLE);
        in_data_g = g_q[0] ? bus.i_in_data[63:32] : bus.i_in_data[31:0];
        in_room   = run & ~bus.i_full_fifoIn & (in_cnt_q < total_q);
        wr        = in_room & bus.i_in_valid[g_q];
        rd_allow  = run & ~bus.i_empty_fifoOut & (rd_cnt_q < total_q);
        pop       = sk_valid & bus.i_out_ready[g_q];
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        total_d   = total_q;
        in_cnt_d  = in_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        endec_d   = endec_q;
        key_d     = key_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req) begin
                    g_d       = sel;
                    grant_d   = N_CH'(1) << sel;
                    endec_d   = bus.i_endec[sel];
                    key_d     = key_sel;
                    total_d   = total_words(len_sel);
                    in_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len_sel == '0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_CFG;
            ST_CFG:   state_d = ST_RUN;
            ST_RUN: begin
                if (wr) begin
                    in_cnt_d = in_cnt_q + WCNT_W'(1);
                end
                if (sk_rd) begin
                    rd_cnt_d = rd_cnt_q + WCNT_W'(1);
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + WCNT_W'(1);
                end
                if (out_cnt_q == total_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                rr_d    = ~g_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Key and direction are pure data; outputs are masked while idle instead.
    always_ff @(posedge i_clk) begin
        endec_q <= endec_d;
        key_q   <= key_d;
    end

    aes_skid2 u_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_allow (rd_allow),
        .o_rd       (sk_rd),
        .i_q        (bus.i_q_fifoOut),
        .i_pop      (pop),
        .o_valid    (sk_valid),
        .o_data     (sk_data)
    );

    // grant_q is one-hot on the owner, so it doubles as the per-channel mask.
    assign bus.o_in_ready     = in_room ? grant_q : '0;
    assign bus.o_write_fifoIn = wr;
    assign bus.o_data_fifoIn  = run ? in_data_g : 32'd0;
    assign bus.o_read_fifoOut = sk_rd;
    assign bus.o_out_valid    = sk_valid ? grant_q : '0;
    assign bus.o_out_data     = sk_valid ? sk_data : 32'd0;
    assign bus.o_grant        = grant_q;
    assign bus.o_done         = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.o_rst_control  = (state_q == ST_FLUSH);
    assign bus.o_param_load   = (state_q == ST_CFG);
    assign bus.o_key_load     = (state_q == ST_CFG);
    assign bus.o_endec        = busy & endec_q;
    assign bus.o_key_data_1   = busy ? key_q[31:0]   : 32'd0;
    assign bus.o_key_data_2   = busy ? key_q[63:32]  : 32'd0;
    assign bus.o_key_data_3   = busy ? key_q[95:64]  : 32'd0;
    assign bus.o_key_data_4   = busy ? key_q[127:96] : 32'd0;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter. The AES datapath is modelled as a
// single FIFO that XORs each word with a constant, so every returned word
// can be predicted from the per-channel source sequence.
`timescale 1ns/1ps
module tb_aes_job_arbiter;

    localparam logic [31:0] MASK = 32'h5A5A_5A5A;
    localparam logic [127:0] KEY0 = {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
    localparam logic [127:0] KEY1 = {32'hF0E0D0C0, 32'hB0A09080, 32'h70605040, 32'h30201000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_job_arbiter_if #(.N_CH(2), .LEN_W(8)) bus ();

    aes_job_arbiter #(.N_CH(2), .LEN_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] word_of(input int c, input int seq);
        return 32'((c + 1) * 32'h1000_0000 + seq);
    endfunction

    // Datapath model: input FIFO feeds output FIFO directly.
    logic [31:0] mem [0:2047];
    int          wp = 0;
    int          rp = 0;
    logic [31:0] q_r = 32'd0;
    assign bus.i_empty_fifoOut = (wp == rp);
    assign bus.i_q_fifoOut     = q_r;

    always @(posedge clk) begin
        if (rst) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (bus.o_write_fifoIn) begin
                mem[wp % 2048] <= bus.o_data_fifoIn ^ MASK;
                wp <= wp + 1;
            end
            if (bus.o_read_fifoOut) begin
                q_r <= mem[rp % 2048];
                rp <= rp + 1;
            end
        end
    end

    // Requester sources and result sinks.
    logic [1:0] src_on = 2'b00;
    int src_rand = 0;
    int snk_mode = 0;
    int cyc = 0;
    int src_seq [2] = '{0, 0};
    int snk_seq [2] = '{0, 0};

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < 2; c++) begin
            bus.i_in_valid[c] = src_on[c] & ((src_rand == 0) || ($urandom_range(0, 1) == 1));
            bus.i_in_data[c*32 +: 32] = word_of(c, src_seq[c]);
            case (snk_mode)
                0:       bus.i_out_ready[c] = 1'b1;
                1:       bus.i_out_ready[c] = ((cyc % 3) == 0);
                default: bus.i_out_ready[c] = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Event monitor.
    int n_wr = 0, n_flush = 0, n_cfg = 0, data_bad = 0;
    int outst = 0, max_outst = 0, grant_jump = 0, multi_hot = 0, wr_full = 0;
    int n_pop [2] = '{0, 0};
    int n_done [2] = '{0, 0};
    logic [1:0] grant_prev = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                src_seq[c] <= 0;
                snk_seq[c] <= 0;
            end
            outst <= 0;
            grant_prev <= 2'b00;
        end else begin
            automatic int npop = 0;
            automatic int nxt;
            if (bus.o_write_fifoIn) n_wr <= n_wr + 1;
            if (bus.o_write_fifoIn && bus.i_full_fifoIn) wr_full <= wr_full + 1;
            if (bus.o_rst_control) n_flush <= n_flush + 1;
            if (bus.o_param_load && bus.o_key_load) n_cfg <= n_cfg + 1;
            for (int c = 0; c < 2; c++) begin
                if (bus.o_in_ready[c] && bus.i_in_valid[c]) src_seq[c] <= src_seq[c] + 1;
                if (bus.o_done[c]) n_done[c] <= n_done[c] + 1;
                if (bus.o_out_valid[c] && bus.i_out_ready[c]) begin
                    npop = npop + 1;
                    if (bus.o_out_data !== (word_of(c, snk_seq[c]) ^ MASK)) data_bad <= data_bad + 1;
                    snk_seq[c] <= snk_seq[c] + 1;
                    n_pop[c] <= n_pop[c] + 1;
                end
            end
            nxt = outst + (bus.o_read_fifoOut ? 1 : 0) - npop;
            outst <= nxt;
            if (nxt > max_outst) max_outst <= nxt;
            if (grant_prev != 2'b00 && bus.o_grant != 2'b00 && bus.o_grant != grant_prev)
                grant_jump <= grant_jump + 1;
            if ($countones(bus.o_in_ready) > 1 || $countones(bus.o_out_valid) > 1)
                multi_hot <= multi_hot + 1;
            grant_prev <= bus.o_grant;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int c, input logic [7:0] len, input logic endec, input logic [127:0] key);
        bus.i_len[c*8 +: 8]     = len;
        bus.i_endec[c]          = endec;
        bus.i_key[c*128 +: 128] = key;
    endtask

    task automatic wait_done(input int max, output logic [1:0] which);
        which = 2'b00;
        for (int i = 0; i < max && which == 2'b00; i++) begin
            tick();
            which = bus.o_done;
        end
        chk("done_within_bound", 64'(which != 2'b00), 64'd1);
    endtask

    int wr0, pop0, pop1, dn0, fl0, cf0;
    logic [1:0] w;

    initial begin
        bus.i_req = 2'b00;
        bus.i_endec = 2'b00;
        bus.i_key = '0;
        bus.i_len = '0;
        bus.i_full_fifoIn = 1'b0;
        rst = 1'b1;
        tick(3);

        // Reset state
        chk("rst_grant",      64'(bus.o_grant), 64'd0);
        chk("rst_done",       64'(bus.o_done), 64'd0);
        chk("rst_ctrl",       64'({bus.o_rst_control, bus.o_param_load, bus.o_key_load, bus.o_endec}), 64'd0);
        chk("rst_fifo_strb",  64'({bus.o_write_fifoIn, bus.o_read_fifoOut}), 64'd0);
        chk("rst_hs",         64'({bus.o_in_ready, bus.o_out_valid}), 64'd0);
        chk("rst_key",        64'(bus.o_key_data_1 | bus.o_key_data_4), 64'd0);
        chk("rst_data",       64'(bus.o_out_data | bus.o_data_fifoIn), 64'd0);
        rst = 1'b0;
        tick();

        // Single job: ch0, len=2, encrypt
        set_job(0, 8'd2, 1'b1, KEY0);
        src_on = 2'b01;
        wr0 = n_wr; pop0 = n_pop[0]; dn0 = n_done[0]; fl0 = n_flush; cf0 = n_cfg;
        bus.i_req[0] = 1'b1;
        tick();
        chk("j1_grant_T1",   64'(bus.o_grant), 64'd1);
        chk("j1_flush_T1",   64'(bus.o_rst_control), 64'd1);
        chk("j1_noload_T1",  64'(bus.o_param_load), 64'd0);
        bus.i_endec[0] = 1'b0;
        bus.i_key[31:0] = 32'hDEAD_BEEF;
        tick();
        chk("j1_load_T2",    64'({bus.o_param_load, bus.o_key_load, bus.o_rst_control}), 64'b110);
        chk("j1_key1",       64'(bus.o_key_data_1), 64'h0001_0203);
        chk("j1_key2",       64'(bus.o_key_data_2), 64'h0405_0607);
        chk("j1_key4",       64'(bus.o_key_data_4), 64'h0C0D_0E0F);
        chk("j1_endec",      64'(bus.o_endec), 64'd1);
        wait_done(200, w);
        chk("j1_done_ch",    64'(w), 64'd1);
        chk("j1_grant_done", 64'(bus.o_grant), 64'd1);
        bus.i_req[0] = 1'b0;
        src_on = 2'b00;
        tick();
        chk("j1_grant_idle", 64'(bus.o_grant), 64'd0);
        chk("j1_writes",     64'(n_wr - wr0), 64'd8);
        chk("j1_words_out",  64'(n_pop[0] - pop0), 64'd8);
        chk("j1_data",       64'(data_bad), 64'd0);
        chk("j1_done_cnt",   64'(n_done[0] - dn0), 64'd1);
        chk("j1_flush_cnt",  64'(n_flush - fl0), 64'd1);
        chk("j1_cfg_cnt",    64'(n_cfg - cf0), 64'd1);

        // Contention after reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        set_job(0, 8'd1, 1'b0, KEY0);
        set_job(1, 8'd1, 1'b1, KEY1);
        src_on = 2'b11;
        bus.i_req = 2'b11;
        tick();
        chk("ct_first_grant", 64'(bus.o_grant), 64'd1);
        wait_done(200, w);
        chk("ct_done_1",      64'(w), 64'd1);
        wait_done(200, w);
        chk("ct_done_2",      64'(w), 64'd2);
        wait_done(200, w);
        chk("ct_done_3",      64'(w), 64'd1);
        bus.i_req = 2'b00;
        src_on = 2'b00;
        tick();
        chk("ct_grant_stable", 64'(grant_jump), 64'd0);
        chk("ct_onehot",       64'(multi_hot), 64'd0);
        chk("ct_data",         64'(data_bad), 64'd0);

        // Backpressure: input FIFO full, then 1-in-3 consumer
        bus.i_full_fifoIn = 1'b1;
        set_job(1, 8'd2, 1'b0, KEY1);
        src_on = 2'b10;
        snk_mode = 1;
        wr0 = n_wr; pop1 = n_pop[1];
        bus.i_req[1] = 1'b1;
        tick(22);
        chk("bp_no_writes",  64'(n_wr - wr0), 64'd0);
        chk("bp_in_ready",   64'(bus.o_in_ready), 64'd0);
        chk("bp_grant",      64'(bus.o_grant), 64'd2);
        bus.i_full_fifoIn = 1'b0;
        wait_done(400, w);
        chk("bp_done_ch",    64'(w), 64'd2);
        bus.i_req[1] = 1'b0;
        src_on = 2'b00;
        snk_mode = 0;
        tick();
        chk("bp_writes",     64'(n_wr - wr0), 64'd8);
        chk("bp_words_out",  64'(n_pop[1] - pop1), 64'd8);
        chk("bp_data",       64'(data_bad), 64'd0);
        chk("bp_outstanding", 64'(max_outst <= 2), 64'd1);
        chk("bp_wr_full",    64'(wr_full), 64'd0);

        // len=0 on ch1
        set_job(1, 8'd0, 1'b1, KEY1);
        fl0 = n_flush; cf0 = n_cfg;
        bus.i_req[1] = 1'b1;
        tick();
        chk("z_grant",   64'(bus.o_grant), 64'd2);
        chk("z_done",    64'(bus.o_done), 64'd2);
        chk("z_ctrl",    64'({bus.o_rst_control, bus.o_param_load, bus.o_key_load}), 64'd0);
        bus.i_req[1] = 1'b0;
        tick();
        chk("z_idle",    64'({bus.o_grant, bus.o_done}), 64'd0);
        chk("z_no_flush", 64'(n_flush - fl0), 64'd0);
        chk("z_no_cfg",  64'(n_cfg - cf0), 64'd0);

        // Short ch0 job so the pointer now favours ch1
        set_job(0, 8'd1, 1'b0, KEY0);
        src_on = 2'b01;
        bus.i_req[0] = 1'b1;
        wait_done(200, w);
        chk("pre_done_ch0", 64'(w), 64'd1);
        bus.i_req[0] = 1'b0;
        src_on = 2'b00;
        tick();

        // Reset mid-RUN on ch1 after 5 words written
        set_job(1, 8'd4, 1'b1, KEY1);
        src_on = 2'b10;
        wr0 = n_wr;
        dn0 = n_done[0] + n_done[1];
        bus.i_req[1] = 1'b1;
        for (int i = 0; i < 60 && (n_wr - wr0) < 5; i++) tick();
        chk("mr_five_written", 64'(n_wr - wr0), 64'd5);
        rst = 1'b1;
        bus.i_req = 2'b00;
        src_on = 2'b00;
        tick();
        chk("mr_grant_done", 64'({bus.o_grant, bus.o_done}), 64'd0);
        chk("mr_ctrl",       64'({bus.o_rst_control, bus.o_param_load, bus.o_key_load, bus.o_endec}), 64'd0);
        chk("mr_strobes",    64'({bus.o_write_fifoIn, bus.o_read_fifoOut, bus.o_in_ready, bus.o_out_valid}), 64'd0);
        chk("mr_data",       64'(bus.o_key_data_1 | bus.o_key_data_3 | bus.o_out_data | bus.o_data_fifoIn), 64'd0);
        tick();
        rst = 1'b0;
        chk("mr_no_done",    64'(n_done[0] + n_done[1] - dn0), 64'd0);
        set_job(0, 8'd1, 1'b0, KEY0);
        set_job(1, 8'd1, 1'b1, KEY1);
        src_on = 2'b11;
        bus.i_req = 2'b11;
        tick();
        chk("mr_next_grant", 64'(bus.o_grant), 64'd1);
        wait_done(200, w);
        chk("mr_done_a",     64'(w), 64'd1);
        wait_done(200, w);
        chk("mr_done_b",     64'(w), 64'd2);
        bus.i_req = 2'b00;
        src_on = 2'b00;
        tick();
        chk("mr_data_ok",    64'(data_bad), 64'd0);

        // Max length with random source and random-stall consumer
        set_job(0, 8'd255, 1'b1, KEY0);
        src_rand = 1;
        snk_mode = 2;
        src_on = 2'b01;
        wr0 = n_wr; pop0 = n_pop[0];
        bus.i_req[0] = 1'b1;
        wait_done(20000, w);
        chk("mx_done_ch",    64'(w), 64'd1);
        bus.i_req[0] = 1'b0;
        src_on = 2'b00;
        tick();
        chk("mx_writes",     64'(n_wr - wr0), 64'd1020);
        chk("mx_words_out",  64'(n_pop[0] - pop0), 64'd1020);
        chk("mx_data",       64'(data_bad), 64'd0);
        chk("mx_outstanding", 64'(max_outst <= 2), 64'd1);
        chk("mx_onehot",     64'(multi_hot), 64'd0);
        chk("mx_grant_stable", 64'(grant_jump), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
